// File: rtl/ospfb_axis_capture_if.sv
// AXI4-Stream beat channel carrying {im, re} FFT samples from the OSPFB.
// The master drives the data and valid/last signals; the slave drives tready.
interface ospfb_axis_capture_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/ospfb_axis_capture.sv
// Frame-aligned AXI4-Stream capture buffer for the OSPFB output.
// Stores FRAMES*FFT_LEN beats and provides a registered, read-first read port.
module ospfb_axis_capture #(
  parameter  int WIDTH   = 16,
  parameter  int FFT_LEN = 64,
  parameter  int FRAMES  = 20,
  localparam int DEPTH   = FRAMES * FFT_LEN,
  localparam int AW      = $clog2(DEPTH),
  localparam int FCW     = $clog2(FRAMES + 1),
  localparam int IW      = $clog2(FFT_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  ospfb_axis_capture_if.slave  s_axis,
  output logic                 full,
  output logic                 capturing,
  output logic [FCW-1:0]       frame_cnt,
  output logic                 tlast_err,
  input  logic [AW-1:0]        rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_CAPTURE,
    S_FULL
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_LEN - 1);

  state_t             state;
  state_t             state_nxt;
  logic               tready_q;
  logic [AW-1:0]      wr_ptr;
  logic [IW-1:0]      idx;
  logic               xfer;
  logic               store;
  logic               arm_ok;
  logic               idx_last;
  logic [2*WIDTH-1:0] mem [DEPTH];

  assign s_axis.tready = tready_q;
  assign xfer          = s_axis.tvalid && tready_q;
  assign store         = (state == S_CAPTURE) && xfer;
  assign idx_last      = (idx == LAST_IDX);
  assign full          = (state == S_FULL);
  assign capturing     = (state == S_CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    arm_ok    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt = S_ALIGN;
          arm_ok    = 1'b1;
        end
      end
      S_ALIGN: begin
        // The tlast beat itself closes the partial frame and is dropped.
        if (xfer && s_axis.tlast) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (store && (wr_ptr == LAST_PTR)) state_nxt = S_FULL;
      end
      S_FULL: begin
        if (arm) begin
          state_nxt = S_ALIGN;
          arm_ok    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tready_q  <= 1'b0;
      wr_ptr    <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (arm_ok) begin
        wr_ptr    <= '0;
        idx       <= '0;
        frame_cnt <= '0;
        tlast_err <= 1'b0;
      end else if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (idx_last) begin
          idx       <= '0;
          frame_cnt <= frame_cnt + FCW'(1);
        end else begin
          idx <= idx + IW'(1);
        end
        // Counting continues regardless; a framing error is only flagged.
        if (s_axis.tlast != idx_last) tlast_err <= 1'b1;
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; only the output register resets.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= s_axis.tdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule
